bit_serializer: RTL and testbench

Upstream feeder for the 3-bit-state `moore_machine`. It accepts parallel words over a valid/ready handshake and emits them one bit per clock, MSB first, on a serial line that drives the machine's `in` input. A single-entry holding register lets the next word be accepted while the current one shifts out, so back-to-back words stream with no idle bit between them. Optionally, an even-parity bit follows each word.

---
 rtl/bit_serializer_pkg.sv | 14 +
 rtl/bit_serializer_if.sv | 16 +
 rtl/bit_serializer_hold_buf.sv | 33 +++
 rtl/bit_serializer.sv | 86 ++++++++
 tb/tb_bit_serializer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared types for bit_serializer: state encoding, default width, counter sizing.
package serializer_pkg;
    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_e;

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction
endpackage

// File: rtl/bit_serializer_if.sv
// Parallel-in handshake plus serial-out bundle for bit_serializer.
interface bit_serializer_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             stall;
    logic             out_bit;
    logic             out_valid;
    logic             done;
    logic             busy;

    modport master (output in_data, in_valid, stall,
                    input  in_ready, out_bit, out_valid, done, busy);
    modport slave  (input  in_data, in_valid, stall,
                    output in_ready, out_bit, out_valid, done, busy);
endinterface

// File: rtl/bit_serializer_hold_buf.sv
// ser_hold_buf: one-entry valid/ready holding register drained by i_pop.
module ser_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_hold,
    output logic             o_hold_valid
);
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_valid;

    // Ready only when empty, so accept and pop are mutually exclusive.
    assign o_ready      = !r_hold_valid && !rst;
    assign o_hold       = r_hold;
    assign o_hold_valid = r_hold_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else if (i_valid && o_ready) begin
            r_hold       <= i_data;
            r_hold_valid <= 1'b1;
        end else if (i_pop) begin
            r_hold_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: word-to-serial shifter, MSB first, gapless with a one-word hold.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module bit_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input logic             clk,
    input logic             rst,
    bit_serializer_if.slave bus
);
    localparam int             CW        = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST      = CW'(WIDTH - 1);
    localparam logic [1:0]     ST_IDLE   = 2'(IDLE);
    localparam logic [1:0]     ST_SHIFT  = 2'(SHIFT);
`ifdef SERIALIZER_PARITY_EN
    localparam logic [1:0]     ST_PARITY = 2'(PARITY);
`endif

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_hold;
    logic             w_hold_valid;
    logic             w_last;
    logic             w_load;

    ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
        .clk          (clk),
        .rst          (rst),
        .i_data       (bus.in_data),
        .i_valid      (bus.in_valid),
        .o_ready      (bus.in_ready),
        .i_pop        (w_load),
        .o_hold       (w_hold),
        .o_hold_valid (w_hold_valid)
    );

`ifdef SERIALIZER_PARITY_EN
    logic r_par;
    assign w_last      = (r_state == ST_PARITY);
    assign bus.out_bit = (r_state == ST_SHIFT)  ? r_shreg[WIDTH-1] :
                         (r_state == ST_PARITY) ? r_par : 1'b0;

    always_ff @(posedge clk) begin
        if (rst)         r_par <= 1'b0;
        else if (w_load) r_par <= ^w_hold;
    end
`else
    assign w_last      = (r_state == ST_SHIFT) && (r_cnt == LAST);
    assign bus.out_bit = (r_state == ST_SHIFT) && r_shreg[WIDTH-1];
`endif

    // Reload on the final bit's edge keeps back-to-back words gapless.
    assign w_load        = !bus.stall && w_hold_valid && ((r_state == ST_IDLE) || w_last);
    assign bus.done      = w_last && !bus.stall;
    assign bus.out_valid = (r_state != ST_IDLE);
    assign bus.busy      = (r_state != ST_IDLE) || w_hold_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (!bus.stall) begin
            if (w_load) begin
                r_shreg <= w_hold;
                r_cnt   <= '0;
                r_state <= ST_SHIFT;
            end else if (r_state == ST_SHIFT) begin
                if (r_cnt == LAST) begin
`ifdef SERIALIZER_PARITY_EN
                    r_state <= ST_PARITY;
`else
                    r_state <= ST_IDLE;
`endif
                end else begin
                    r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
                    r_cnt   <= r_cnt + 1'b1;
                end
            end else begin
                r_state <= ST_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: queue-based bit-stream model plus directed literals.
module tb_bit_serializer;
    localparam int W = 8;
`ifdef SERIALIZER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bit_serializer_if #(.WIDTH(W)) bif ();
    bit_serializer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bif));

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    endtask

    // Model: words waiting (hold) and the word being presented with its bit index.
    logic [W-1:0] wq[$];
    logic [W-1:0] cur;
    bit           act = 0;
    int           idx = 0;
    int           cyc = 0;
    bit           started = 0;
    logic         cap[$];
    int           done_q[$];

    function automatic logic bitof(input logic [W-1:0] w, input int i);
        if (i < W) return w[W-1-i];
        return ^w;
    endfunction

    always @(posedge clk) begin
        bit rdy, freed;
        cyc++;
        if (rst) begin
            wq.delete();
            act = 0;
            idx = 0;
        end else begin
            rdy   = (wq.size() == 0);
            freed = !act || (idx == NB - 1);
            if (!bif.stall) begin
                if (act) begin
                    if (idx == NB - 1) act = 0;
                    else idx++;
                end
                if (freed && wq.size() > 0) begin
                    cur = wq.pop_front();
                    idx = 0;
                    act = 1;
                end
            end
            if (bif.in_valid && rdy) wq.push_back(bif.in_data);
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", 32'(bif.out_valid), 32'(act));
            chk("out_bit",   32'(bif.out_bit),   32'(act ? bitof(cur, idx) : 1'b0));
            chk("done",      32'(bif.done),      32'(act && idx == NB - 1 && !bif.stall));
            chk("in_ready",  32'(bif.in_ready),  32'(!rst && wq.size() == 0));
            chk("busy",      32'(bif.busy),      32'(act || wq.size() > 0));
            if (bif.out_valid && !bif.stall) cap.push_back(bif.out_bit);
            if (bif.done) done_q.push_back(cyc);
        end
    end

    function automatic logic [31:0] packcap();
        logic [31:0] v = 0;
        foreach (cap[i]) v = (v << 1) | 32'(cap[i]);
        return v;
    endfunction

    task automatic send(input logic [W-1:0] w);
        int n = 0;
        bif.in_data  = w;
        bif.in_valid = 1'b1;
        do begin @(negedge clk); n++; end while (!bif.in_ready && n < 100);
        if (n >= 100) chk("send_timeout", 32'(bif.in_ready), 32'd1);
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        do begin @(negedge clk); n++; end while (bif.busy && n < 200);
        if (n >= 200) chk("drain_timeout", 32'(bif.busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int nacc;
        bif.in_data  = '0;
        bif.in_valid = 1'b0;
        bif.stall    = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bif.in_ready), 32'd0);
        chk("rst_valid", 32'(bif.out_valid), 32'd0);
        chk("rst_busy",  32'(bif.busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", 32'(bif.in_ready), 32'd1);
        @(posedge clk); #1;

        // Single word: stream and latency
        cap.delete(); done_q.delete();
        send(8'hA5);
        nacc = cyc;
        chk("rdy_full", 32'(bif.in_ready), 32'd0);
        drain();
        chk("a5_len", 32'(cap.size()), 32'(NB));
`ifdef SERIALIZER_PARITY_EN
        chk("a5_bits", packcap(), 32'(9'b101001010));
`else
        chk("a5_bits", packcap(), 32'h000000A5);
`endif
        chk("a5_ndone", 32'(done_q.size()), 32'd1);
        chk("a5_lat", 32'(done_q[0] - nacc), 32'(NB));
        chk("idle_bit", 32'(bif.out_bit), 32'd0);

        // Parity-sensitive word
        cap.delete();
        send(8'h07);
        drain();
`ifdef SERIALIZER_PARITY_EN
        chk("w07_bits", packcap(), 32'(9'b000001111));
`else
        chk("w07_bits", packcap(), 32'h00000007);
`endif

        // Back-to-back, gapless
        cap.delete(); done_q.delete();
        send(8'hA5);
        send(8'h3C);
        drain();
        chk("b2b_len", 32'(cap.size()), 32'(2 * NB));
`ifdef SERIALIZER_PARITY_EN
        chk("b2b_bits", packcap(), 32'(18'b101001010_001111000));
`else
        chk("b2b_bits", packcap(), 32'h0000A53C);
`endif
        chk("b2b_gap", 32'(done_q[1] - done_q[0]), 32'(NB));

        // Stall at 4th bit for 2 cycles, word offered during stall
        cap.delete(); done_q.delete();
        send(8'hA5);
        nacc = cyc;
        repeat (4) @(posedge clk);
        #1;
        bif.stall    = 1'b1;
        bif.in_data  = 8'h0F;
        bif.in_valid = 1'b1;
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        chk("stall_accept", 32'(bif.in_ready), 32'd0);
        @(posedge clk); #1;
        bif.stall = 1'b0;
        drain();
        chk("stall_done", 32'(done_q[0] - nacc), 32'(NB + 2));
`ifdef SERIALIZER_PARITY_EN
        chk("stall_bits", packcap(), 32'(18'b101001010_000011110));
`else
        chk("stall_bits", packcap(), 32'h0000A50F);
`endif

        // Reset mid-word with a held word
        cap.delete();
        send(8'hFF);
        send(8'h0F);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(bif.out_valid), 32'd0);
        chk("mid_rst_bit",   32'(bif.out_bit), 32'd0);
        chk("mid_rst_busy",  32'(bif.busy), 32'd0);
        chk("mid_rst_done",  32'(bif.done), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("mid_rst_len", 32'(cap.size()), 32'd3);
        chk("mid_rst_bits", packcap(), 32'd7);

        // Randomized traffic with stalls and occasional reset
        for (int i = 0; i < 600; i++) begin
            bif.in_valid = ($urandom % 3) != 0;
            bif.in_data  = W'($urandom);
            bif.stall    = ($urandom % 8) == 0;
            rst          = ($urandom % 200) == 0;
            @(posedge clk); #1;
        end
        bif.in_valid = 1'b0;
        bif.stall    = 1'b0;
        rst          = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
